// File: rtl/cu_pkg.sv
// Shared definitions for the iterative control unit: state encoding, mode
// constants and the iteration-counter width helper.
package cu_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_TEST  = 3'd2;
    localparam logic [2:0] ST_OPA   = 3'd3;
    localparam logic [2:0] ST_OPB   = 3'd4;
    localparam logic [2:0] ST_SHIFT = 3'd5;
    localparam logic [2:0] ST_FIX   = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        TEST  = ST_TEST,
        OPA   = ST_OPA,
        OPB   = ST_OPB,
        SHIFT = ST_SHIFT,
        FIX   = ST_FIX,
        DONE  = ST_DONE
    } state_e;

    localparam logic OP_FULL = 1'b0;
    localparam logic OP_SKIP = 1'b1;

    // Counter width for n iterations; never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iter_counter.sv
// Iteration counter: synchronous clear, saturating increment that stops at LAST,
// and a flag marking the final iteration.
module iter_counter #(
    parameter int           W    = 3,
    parameter logic [W-1:0] LAST = '1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         last
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign last = (q_q == LAST);
    assign q    = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !last) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/control_unit_iter.sv
// Iterative datapath sequencer: LOAD, then ITER rounds of TEST/OP/SHIFT,
// then FIX and a one-cycle DONE pulse.
module control_unit_iter
    import cu_pkg::*;
#(
    parameter  int ITER = 8,
    localparam int CW   = cw_of(ITER)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          bgn,
    input  logic          op,
    input  logic          s,
    output logic          c0,
    output logic          c1,
    output logic          c2,
    output logic          c3,
    output logic          c4,
    output logic          c5,
    output logic          c6,
    output logic          stop,
    output logic          busy,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(ITER - 1);

    state_e state_q;
    state_e state_d;
    logic   op_q;
    logic   cnt_last;

    iter_counter #(
        .W    (CW),
        .LAST (LAST_IDX)
    ) u_iter_counter (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (state_q == LOAD),
        .inc   (state_q == SHIFT),
        .q     (cnt),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            op_q    <= OP_FULL;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                op_q <= op;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        c0      = 1'b0;
        c1      = 1'b0;
        c2      = 1'b0;
        c3      = 1'b0;
        c4      = 1'b0;
        c5      = 1'b0;
        c6      = 1'b0;
        stop    = 1'b0;
        busy    = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bgn) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                c0      = 1'b1;
                state_d = TEST;
            end
            TEST: begin
                c1 = 1'b1;
                if (s) begin
                    state_d = OPA;
                end else if (op_q == OP_FULL) begin
                    state_d = OPB;
                end else begin
                    state_d = SHIFT;
                end
            end
            OPA: begin
                c2      = 1'b1;
                state_d = SHIFT;
            end
            OPB: begin
                c2      = 1'b1;
                c3      = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                c4 = 1'b1;
                // Final shift also applies the op-enable when the datapath still reports s.
                if (cnt_last) begin
                    c2      = s;
                    state_d = FIX;
                end else begin
                    state_d = TEST;
                end
            end
            FIX: begin
                c5      = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                c6      = 1'b1;
                stop    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
